// File: rtl/mpc_qp_admm_vec_ram_sched_pkg.sv
// rtl/mpc_qp_admm_vec_ram_sched_pkg.sv - shared types and helpers for the ADMM vector RAM scheduler
package mpc_qp_admm_vec_ram_sched_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } sched_state_e;

  localparam int NREQ_DEFAULT = 3;

  // Width of a requester index; never below one bit
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mpc_qp_admm_rr_arbiter.sv
// rtl/mpc_qp_admm_rr_arbiter.sv - round-robin grant and pointer for a shared RAM port
module mpc_qp_admm_rr_arbiter
  import mpc_qp_admm_vec_ram_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int PW   = ptr_width(NREQ)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   gidx,
  output logic            gvalid
);

  logic [PW-1:0] ptr;
  int            idx;

  // First asserted request at or after the pointer, wrapping at NREQ
  always_comb begin
    gvalid = 1'b0;
    gidx   = '0;
    idx    = 0;
    if (en) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (int'(ptr) + k) % NREQ;
        if (!gvalid && req[idx]) begin
          gvalid = 1'b1;
          gidx   = PW'(idx);
        end
      end
    end
  end

  assign grant = gvalid ? (NREQ'(1) << gidx) : '0;

  // Move the pointer just past the winner so it gets lowest priority next
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (gvalid) begin
      ptr <= (int'(gidx) == NREQ - 1) ? '0 : gidx + PW'(1);
    end
  end

endmodule

// File: rtl/mpc_qp_admm_vec_ram_sched.sv
// rtl/mpc_qp_admm_vec_ram_sched.sv - arbitrated access and clear sequencer for one ADMM vector RAM
module mpc_qp_admm_vec_ram_sched
  import mpc_qp_admm_vec_ram_sched_pkg::*;
#(
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 5,
  parameter int AddressRange = 24,
  parameter int NREQ         = NREQ_DEFAULT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clr_start,
  output logic                         clr_busy,
  output logic                         clr_done,
  input  logic [NREQ-1:0]              req_valid,
  output logic [NREQ-1:0]              req_ready,
  input  logic [NREQ-1:0]              req_we,
  input  logic [NREQ*AddressWidth-1:0] req_addr,
  input  logic [NREQ*DataWidth-1:0]    req_wdata,
  output logic [NREQ-1:0]              rsp_valid,
  output logic [DataWidth-1:0]         rsp_rdata,
  output logic                         err_oob,
  output logic [AddressWidth-1:0]      ram_address0,
  output logic                         ram_ce0,
  output logic                         ram_we0,
  output logic [DataWidth-1:0]         ram_d0,
  input  logic [DataWidth-1:0]         ram_q0
);

  localparam int PW = ptr_width(NREQ);

  sched_state_e              state, state_nxt;
  logic [AddressWidth-1:0]   clr_cnt;
  logic                      clr_last;
  logic                      arb_en;
  logic [NREQ-1:0]           grant;
  logic [PW-1:0]             gidx;
  logic                      gvalid;
  logic [AddressWidth-1:0]   g_addr;
  logic [DataWidth-1:0]      g_wdata;
  logic                      g_we;
  logic                      g_oob;
  logic [NREQ-1:0]           rsp_valid_q;
  logic                      rsp_oob_q;

  assign clr_last = (clr_cnt == AddressWidth'(AddressRange - 1));

  // Arbitrate only in IDLE; a clear request takes the cycle, and nothing is granted in reset
  assign arb_en = (state == ST_IDLE) && !clr_start && reset;

  mpc_qp_admm_rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .clk    (clk),
    .reset  (reset),
    .en     (arb_en),
    .req    (req_valid),
    .grant  (grant),
    .gidx   (gidx),
    .gvalid (gvalid)
  );

  assign g_addr  = req_addr[int'(gidx)*AddressWidth +: AddressWidth];
  assign g_wdata = req_wdata[int'(gidx)*DataWidth +: DataWidth];
  assign g_we    = req_we[gidx];
  assign g_oob   = (int'(g_addr) >= AddressRange);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state: clear runs once over every valid entry, restarts are ignored while busy
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (clr_start) state_nxt = ST_CLEAR;
      ST_CLEAR: if (clr_last)  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Clear address counter, parked at zero outside CLEAR
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 clr_cnt <= '0;
    else if (state == ST_CLEAR) clr_cnt <= clr_last ? '0 : clr_cnt + AddressWidth'(1);
    else                        clr_cnt <= '0;
  end

  // RAM port and handshake outputs; out-of-range grants are accepted but never reach the RAM
  always_comb begin
    clr_busy     = 1'b0;
    clr_done     = 1'b0;
    req_ready    = '0;
    ram_ce0      = 1'b0;
    ram_we0      = 1'b0;
    ram_address0 = '0;
    ram_d0       = '0;
    case (state)
      ST_CLEAR: begin
        clr_busy     = 1'b1;
        clr_done     = clr_last;
        ram_ce0      = 1'b1;
        ram_we0      = 1'b1;
        ram_address0 = clr_cnt;
      end
      default: begin
        req_ready = grant;
        if (gvalid) begin
          ram_ce0      = !g_oob;
          ram_we0      = g_we && !g_oob;
          ram_address0 = g_addr;
          ram_d0       = g_wdata;
        end
      end
    endcase
  end

  // Read responses line up with the RAM's one-cycle read data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid_q <= '0;
      rsp_oob_q   <= 1'b0;
    end else begin
      rsp_valid_q <= g_we ? '0 : grant;
      rsp_oob_q   <= gvalid && g_oob && !g_we;
    end
  end

  // Sticky out-of-range flag, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)               err_oob <= 1'b0;
    else if (gvalid && g_oob) err_oob <= 1'b1;
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = (|rsp_valid_q && !rsp_oob_q) ? ram_q0 : '0;

endmodule
